// File: rtl/sprite_draw_if.sv
// -----------------------------------------------------------------------------
// sprite_draw_if
//   Bundles the requester handshake and the datapath drive of the sprite
//   drawing controller.
//
//   Requester side (driven by master):
//     req        [1:0]   per-requester move request, level, held until ack
//     req_x      [15:0]  new x origin; [7:0] requester 0, [15:8] requester 1
//     req_y      [13:0]  new y origin; [6:0] requester 0, [13:7] requester 1
//     req_color  [5:0]   sprite colour; [2:0] requester 0, [5:3] requester 1
//   Controller side (driven by slave):
//     ack        [1:0]   one-cycle pulse per requester when its move is done
//     busy               high whenever the controller is not idle
//     x0, y0             datapath sprite origin
//     off_x, off_y       pixel offset into the sprite
//     undraw             datapath outputs background instead of colour
//     color              sprite colour to the datapath
//     plot               VGA write enable for this cycle's pixel
// -----------------------------------------------------------------------------
interface sprite_draw_if #(
    parameter int SIZE_LOG2 = 4
);
    logic [1:0]           req;
    logic [15:0]          req_x;
    logic [13:0]          req_y;
    logic [5:0]           req_color;

    logic [1:0]           ack;
    logic                 busy;
    logic [7:0]           x0;
    logic [6:0]           y0;
    logic [SIZE_LOG2-1:0] off_x;
    logic [SIZE_LOG2-1:0] off_y;
    logic                 undraw;
    logic [2:0]           color;
    logic                 plot;

    modport master (
        output req, req_x, req_y, req_color,
        input  ack, busy, x0, y0, off_x, off_y, undraw, color, plot
    );

    modport slave (
        input  req, req_x, req_y, req_color,
        output ack, busy, x0, y0, off_x, off_y, undraw, color, plot
    );
endinterface

// File: rtl/sprite_draw_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_draw_ctrl
//   Sequencer and round-robin arbiter for the shared sprite datapath in front
//   of the VGA adapter. Two requesters ask to move a square sprite; the
//   granted one is first erased at its last drawn position (if it has ever
//   been drawn), then drawn at the new position, then acknowledged.
//
//   Ports:
//     clock   system clock, rising edge
//     reset   synchronous, active-high; aborts any operation without ack
//     bus     sprite_draw_if.slave (request handshake + datapath drive)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request; arbitrates and latches the move
//   ERASE  | walks the sprite at the old origin with undraw set
//   DRAW   | walks the sprite at the new origin with the latched colour
//   DONE   | one-cycle ack; records new origin as the drawn position
// -----------------------------------------------------------------------------
module sprite_draw_ctrl #(
    parameter int SIZE_LOG2 = 4
) (
    input  logic          clock,
    input  logic          reset,
    sprite_draw_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [SIZE_LOG2-1:0] OFF_LAST = '1;

    logic [1:0]           state;
    logic                 grant;
    logic                 last_grant;
    logic [1:0]           drawn_valid;
    logic [7:0]           old_x [2];
    logic [6:0]           old_y [2];
    logic [7:0]           new_x;
    logic [6:0]           new_y;
    logic [2:0]           new_color;
    logic [SIZE_LOG2-1:0] off_x_q;
    logic [SIZE_LOG2-1:0] off_y_q;

    logic                 next_grant;
    logic [7:0]           sel_x;
    logic [6:0]           sel_y;
    logic [2:0]           sel_color;
    logic                 last_pixel;

    // Round-robin: a lone request wins outright, a tie goes to whoever was
    // not served last. last_grant resets to 1 so requester 0 wins the first tie.
    always_comb begin
        next_grant = 1'b0;
        case (bus.req)
            2'b01:   next_grant = 1'b0;
            2'b10:   next_grant = 1'b1;
            2'b11:   next_grant = ~last_grant;
            default: next_grant = 1'b0;
        endcase
    end

    assign sel_x      = next_grant ? bus.req_x[15:8]    : bus.req_x[7:0];
    assign sel_y      = next_grant ? bus.req_y[13:7]    : bus.req_y[6:0];
    assign sel_color  = next_grant ? bus.req_color[5:3] : bus.req_color[2:0];

    assign last_pixel = (off_x_q == OFF_LAST) && (off_y_q == OFF_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            drawn_valid <= 2'b00;
            old_x[0]    <= '0;
            old_x[1]    <= '0;
            old_y[0]    <= '0;
            old_y[1]    <= '0;
            new_x       <= '0;
            new_y       <= '0;
            new_color   <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        new_x      <= sel_x;
                        new_y      <= sel_y;
                        new_color  <= sel_color;
                        state      <= drawn_valid[next_grant] ? S_ERASE : S_DRAW;
                    end
                end

                // Raster walk shared by both passes. Offsets wrap back to zero
                // on their own after the last pixel, ready for the next pass.
                S_ERASE, S_DRAW: begin
                    off_x_q <= off_x_q + 1'b1;
                    if (off_x_q == OFF_LAST) begin
                        off_y_q <= off_y_q + 1'b1;
                    end
                    if (last_pixel) begin
                        state <= (state == S_ERASE) ? S_DRAW : S_DONE;
                    end
                end

                S_DONE: begin
                    old_x[grant]       <= new_x;
                    old_y[grant]       <= new_y;
                    drawn_valid[grant] <= 1'b1;
                    state              <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath drive is purely a function of state so every output is zero
    // in IDLE and DONE, and plot/ack can never overlap.
    assign bus.busy   = (state != S_IDLE);
    assign bus.plot   = (state == S_ERASE) || (state == S_DRAW);
    assign bus.undraw = (state == S_ERASE);
    assign bus.off_x  = off_x_q;
    assign bus.off_y  = off_y_q;
    assign bus.color  = (state == S_DRAW) ? new_color : 3'b000;

    always_comb begin
        bus.x0 = 8'd0;
        bus.y0 = 7'd0;
        case (state)
            S_ERASE: begin
                bus.x0 = old_x[grant];
                bus.y0 = old_y[grant];
            end
            S_DRAW: begin
                bus.x0 = new_x;
                bus.y0 = new_y;
            end
            default: begin
                bus.x0 = 8'd0;
                bus.y0 = 7'd0;
            end
        endcase
    end

    always_comb begin
        bus.ack = 2'b00;
        if (state == S_DONE) begin
            bus.ack = grant ? 2'b10 : 2'b01;
        end
    end

endmodule
